// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FWFT FIFO buffering ALU results with flags recomputed over the selected width
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          upstream handshake; in_ready = not full
//   in_opcode, in_result,
//   in_mult_result             ALU opcode and results captured at push
//   out_valid/out_ready        downstream handshake; out_valid = not empty
//   out_data, out_is_mult,
//   out_zero, out_sign         head entry, all zero while empty
//   count                      occupancy
//   zero_seen, clear_sticky    sticky record of a zero entry being pushed, and its clear
//   stall_cnt                  saturating count of cycles upstream was refused
module alu_result_fifo #(
    parameter int N     = 2,
    parameter int DEPTH = 4,
    parameter int SW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_opcode,
    input  logic [N-1:0]             in_result,
    input  logic [2*N-1:0]           in_mult_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*N-1:0]           out_data,
    output logic                     out_is_mult,
    output logic                     out_zero,
    output logic                     out_sign,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     zero_seen,
    input  logic                     clear_sticky,
    output logic [SW-1:0]            stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * N + 3;

    // entry layout: {is_mult, zero, sign, data}
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop, in_is_mult, in_zero, in_sign;
    logic [2*N-1:0]   in_data;
    logic [EW-1:0]    head;

    assign in_is_mult = in_opcode == 4'b1001;
    assign in_data    = in_is_mult ? in_mult_result : {{N{1'b0}}, in_result};
    assign in_zero    = in_data == '0;
    assign in_sign    = in_is_mult ? in_mult_result[2*N-1] : in_result[N-1];

    assign in_ready   = count != CW'(DEPTH);
    assign out_valid  = count != '0;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    // gate the head so stale storage never shows while empty
    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_is_mult, out_zero, out_sign, out_data} = head;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_is_mult, in_zero, in_sign, in_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            zero_seen <= 1'b0;
            stall_cnt <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            count     <= count + CW'(push) - CW'(pop);
            // a new zero push wins over a simultaneous clear
            zero_seen <= (push && in_zero) || (zero_seen && !clear_sticky);
            stall_cnt <= stall_cnt + SW'(in_valid && !in_ready && stall_cnt != '1);
        end
    end
endmodule
